// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package common;

    // The stored tag field is sized for the widest tag a configuration may use.
    // Narrower tags are zero-extended on both write and compare, so every bit
    // of the field takes part in the match.
    localparam int BP_TAG_MAX = 32;

    // Counter value after reset (weakly not-taken) and on a fresh allocation
    // (weakly taken, because allocation only happens on a taken branch).
    localparam logic [1:0] BP_CNT_INIT  = 2'd1;
    localparam logic [1:0] BP_CNT_ALLOC = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        logic [1:0]            cnt;
        logic [63:0]           target;
    } bp_entry_t;

    // 2-bit saturating counter step: up on taken, down on not taken.
    function automatic logic [1:0] bp_cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, response and resolution-update bundle between fetch/execute and the predictor.
// Latency: n/a (wires only).
// Backpressure: stall freezes the response; there is no ready on either channel.
// master: fetch/execute side (drives req_*, stall, upd_*; receives resp_*).
// slave : predictor side.
interface branch_predictor_if;
    logic        req_valid;
    logic [63:0] req_pc;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_pc;
    logic        resp_hit;
    logic        resp_taken;
    logic [63:0] resp_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;

    modport master (
        output req_valid, req_pc, stall,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  resp_valid, resp_pc, resp_hit, resp_taken, resp_target
    );

    modport slave (
        input  req_valid, req_pc, stall,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output resp_valid, resp_pc, resp_hit, resp_taken, resp_target
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor with 2-bit counters and stored targets.
// Latency: lookup response registered, 1 cycle; updates land at the sampling edge.
// Backpressure: stall holds resp_* and ignores req_*; updates still apply.
// Ports: clk, rst (sync, active-high); bp (slave) carries req_*/stall in,
//        resp_* out, and the upd_* resolution channel in.
module branch_predictor
    import common::*;
#(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Flop array rather than a RAM so reset can clear every entry in one cycle.
    bp_entry_t table_q [ENTRIES];

    logic [IDX_BITS-1:0]   req_idx;
    logic [IDX_BITS-1:0]   upd_idx;
    logic [BP_TAG_MAX-1:0] req_tag;
    logic [BP_TAG_MAX-1:0] upd_tag;
    bp_entry_t             req_ent;
    bp_entry_t             upd_ent;
    logic                  lk_hit;
    logic                  lk_taken;
    logic [63:0]           lk_target;
    logic                  upd_hit;

    logic        resp_valid_q;
    logic [63:0] resp_pc_q;
    logic        resp_hit_q;
    logic        resp_taken_q;
    logic [63:0] resp_target_q;

    assign req_idx = bp.req_pc[IDX_BITS+1:2];
    assign upd_idx = bp.upd_pc[IDX_BITS+1:2];
    assign req_tag = BP_TAG_MAX'(bp.req_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);
    assign upd_tag = BP_TAG_MAX'(bp.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);

    // Lookup reads the table as it stands before this edge's update: no bypass.
    assign req_ent   = table_q[req_idx];
    assign lk_hit    = req_ent.valid && (req_ent.tag == req_tag);
    assign lk_taken  = lk_hit && req_ent.cnt[1];
    assign lk_target = lk_taken ? req_ent.target : bp.req_pc + 64'd4;

    assign upd_ent = table_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    // Alignment bits and PC bits above the tag play no part in an update.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{bp.upd_pc[63:IDX_BITS+TAG_BITS+2], bp.upd_pc[1:0]};

    // Response register. Idle cycles clear only resp_valid; the payload holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_pc_q     <= '0;
            resp_hit_q    <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_target_q <= '0;
        end else if (!bp.stall) begin
            resp_valid_q <= bp.req_valid;
            if (bp.req_valid) begin
                resp_pc_q     <= bp.req_pc;
                resp_hit_q    <= lk_hit;
                resp_taken_q  <= lk_taken;
                resp_target_q <= lk_target;
            end
        end
    end

    // Table update. A not-taken miss leaves the table alone; a taken miss
    // claims the slot whatever currently lives there.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].cnt   <= BP_CNT_INIT;
            end
        end else if (bp.upd_valid) begin
            if (upd_hit) begin
                table_q[upd_idx].cnt <= bp_cnt_next(upd_ent.cnt, bp.upd_taken);
                if (bp.upd_taken) begin
                    table_q[upd_idx].target <= bp.upd_target;
                end
            end else if (bp.upd_taken) begin
                table_q[upd_idx].valid  <= 1'b1;
                table_q[upd_idx].tag    <= upd_tag;
                table_q[upd_idx].cnt    <= BP_CNT_ALLOC;
                table_q[upd_idx].target <= bp.upd_target;
            end
        end
    end

    assign bp.resp_valid  = resp_valid_q;
    assign bp.resp_pc     = resp_pc_q;
    assign bp.resp_hit    = resp_hit_q;
    assign bp.resp_taken  = resp_taken_q;
    assign bp.resp_target = resp_target_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped table of tagged entries, each holding a 2-bit saturating counter and a branch target. It answers one lookup per cycle, registered, with a taken/not-taken guess and a next PC. It takes one resolution update per cycle from the execute/memory stage. The `isPrediction`/`predictionHit` pair consumed by the prediction statistics monitor is derived from this block's `resp_taken`/`resp_target` once the branch resolves.

## Interface
- `IDX_BITS`, default 6: table has 2^IDX_BITS entries.
- `TAG_BITS`, default 10: tag width stored per entry.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  lookup request this cycle.
- `req_pc`  in  64  PC being fetched (4-byte aligned).
- `stall`  in  1  hold the current response; ignore `req_valid`.
- `resp_valid`  out  1  response valid.
- `resp_pc`  out  64  PC the response belongs to.
- `resp_hit`  out  1  tag match on a valid entry.
- `resp_taken`  out  1  predicted taken.
- `resp_target`  out  64  predicted next PC.
- `upd_valid`  in  1  resolution update this cycle.
- `upd_pc`  in  64  PC of the resolved control-flow instruction.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  64  actual taken target.

## Operation
- Index is `pc[IDX_BITS+1:2]`. Tag is `pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]`.
- Each entry holds `valid`, `tag`, `cnt[1:0]` and `target[63:0]`.
- Lookup:
  - `hit` = `valid` && tag match.
  - `taken` = `hit` && `cnt[1]`.
  - `target` = entry `target` if `taken`, else `req_pc+4` (64-bit wrap, no carry out).
- Update on a hit:
  - `upd_taken` increments `cnt`, saturating at 3; not taken decrements `cnt`, saturating at 0.
  - When `upd_taken`, `target` is overwritten with `upd_target`.
- Update on a miss with `upd_taken`=1: allocate or overwrite the entry with `valid`=1, new `tag`, `cnt`=2, `target`=`upd_target`.
- Update on a miss with `upd_taken`=0: the table is unchanged.
- Reset: every entry gets `valid`=0 and `cnt`=1; tags and targets are don't-care.

## Timing
- Lookup latency is 1 cycle. `req_valid`/`req_pc` sampled at edge N appear on `resp_*` after edge N.
- When `stall`=1, all `resp_*` hold their values and `req_*` is ignored. Updates are still applied while stalled.
- When `req_valid`=0 and `stall`=0, `resp_valid` is 0 next cycle and the other `resp_*` fields hold.
- Update latency is 1 cycle. The table changes at the edge that samples `upd_valid`=1.
- A lookup and an update to the same index at the same edge: the response reflects the pre-update entry; there is no bypass.
- During reset and after release, all outputs are 0: `resp_valid`, `resp_hit`, `resp_taken`, `resp_pc` and `resp_target`. `rst` overrides `stall` and `upd_valid`.
- `rst` asserted mid-stream drops any pending response. The first post-reset lookup misses.

## Structure
- Shared package `common` holds:
  - `bp_entry_t` (packed: `valid`, `tag`, `cnt`, `target`).
  - the function `bp_cnt_next(cnt, taken)` for saturating counter update.
  - the localparam `BP_CNT_INIT` = 2'd1.
- The table is a flop array inside `branch_predictor`. It is not an SRAM macro, so that single-cycle reset clear is possible.
- There is no sub-module. The response register and table update are two `always_ff` blocks in one module.

## Test plan
- Reset, then lookup PC 0x80000000 -> next cycle `resp_valid`=1, `resp_hit`=0, `resp_taken`=0, `resp_target`=0x80000004.
- Update PC 0x80000010 taken to target 0x80000100, then look it up -> `hit`=1, `taken`=1, `target`=0x80000100.
- Apply 3 not-taken updates to that PC -> `cnt` goes 2 to 1 to 0 to 0 (saturates); the lookup gives `taken`=0 and `target`=0x80000014.
- Aliasing: update 0x80000010 taken, then update 0x80001010 taken (same index, different tag), then look up 0x80000010 -> `hit`=0.
- Same-edge lookup and update on an empty entry -> response `hit`=0; a lookup on the following cycle gives `hit`=1.
- Hold `stall`=1 for 3 cycles while changing `req_pc` -> `resp_*` unchanged. Asserting `rst` during the stall -> `resp_valid`=0 the next cycle.
